// File: rtl/bcd_cnt_pkg.sv
// Shared constants, digit type and load-clamp helper for the BCD cascade counter.
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Force an out-of-range nibble (A-F) to the largest legal BCD digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nib);
        return (nib > BCD_NINE) ? BCD_NINE : nib;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD nibble register: sync clear > sync load > enabled step.
// Down-count support is built only when BCD_CNT_DOWN_EN is defined.
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       ena,
`ifdef BCD_CNT_DOWN_EN
    input  logic       up,
`endif
    output bcd_digit_t d
);

    // Digit state: clear wins over load, load wins over stepping.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            d <= BCD_ZERO;
        end else if (load) begin
            d <= load_val;
        end else if (ena) begin
`ifdef BCD_CNT_DOWN_EN
            if (up) begin
                d <= (d == BCD_NINE) ? BCD_ZERO : d + 4'd1;
            end else begin
                d <= (d == BCD_ZERO) ? BCD_NINE : d - 4'd1;
            end
`else
            d <= (d == BCD_NINE) ? BCD_ZERO : d + 4'd1;
`endif
        end
    end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Parametrised N-digit BCD counter with cascade enables, terminal compare,
// wrap/hold mode and clamped parallel load.
// Optional down counting (and the up_dn port) is built with BCD_CNT_DOWN_EN.
module bcd_cascade_counter
    import bcd_cnt_pkg::*;
#(
    parameter int                    DIGITS  = 4,
    parameter logic [4*DIGITS-1:0]   MAX_BCD = 16'h9675
)(
    input  logic                  clk,
    input  logic                  rstbutton,
    input  logic                  ena0in,
`ifdef BCD_CNT_DOWN_EN
    input  logic                  up_dn,
`endif
    input  logic                  wrap,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic [4*DIGITS-1:0]   q,
    output logic [DIGITS-1:0]     dig_ena,
    output logic                  tc,
    output logic                  halted
);

    localparam int W = 4 * DIGITS;

    logic         up;
    logic         at_term;
    logic         term_evt;
    logic         dig_load;
    logic [W-1:0] nib_clamped;
    logic [W-1:0] load_val;
    logic [W-1:0] wrap_val;
    logic [W-1:0] dig_load_val;

`ifdef BCD_CNT_DOWN_EN
    assign up = up_dn;
`else
    assign up = 1'b1;
`endif

    // Load value: clamp each nibble to 9, then clamp the packed value to the terminal.
    // BCD ordering matches binary ordering, so a plain unsigned compare is valid.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        nib_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_clamped[4*i +: 4] = bcd_clamp(load_data[4*i +: 4]);
        end
        load_val = (nib_clamped > MAX_BCD) ? MAX_BCD : nib_clamped;
    end

    // Terminal detect on the whole packed value, and the value a wrap reloads.
    always_comb begin
        at_term  = up ? (q == MAX_BCD) : (q == '0);
        wrap_val = up ? '0 : MAX_BCD;
        term_evt = ena0in & ~halted & ~load & at_term;
    end

    // Cascade chain: a digit steps when all lower digits are at their roll-over value.
    always_comb begin
        dig_ena    = '0;
        dig_ena[0] = ena0in & ~halted & ~load;
        for (int i = 1; i < DIGITS; i++) begin
            dig_ena[i] = dig_ena[i-1] &
                         (q[4*(i-1) +: 4] == (up ? BCD_NINE : BCD_ZERO));
        end
    end

    // Digit load path is shared by the parallel load and the terminal wrap.
    always_comb begin
        dig_load     = load | (term_evt & wrap);
        dig_load_val = load ? load_val : wrap_val;
    end

    // Digit registers; stepping is suppressed at the terminal value.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .clear    (rstbutton),
            .load     (dig_load),
            .load_val (dig_load_val[4*g +: 4]),
            .ena      (dig_ena[g] & ~at_term),
`ifdef BCD_CNT_DOWN_EN
            .up       (up),
`endif
            .d        (q[4*g +: 4])
        );
    end

    // Terminal pulse and hold flag; load clears both, reset suppresses a pending pulse.
    always_ff @(posedge clk) begin
        if (rstbutton) begin
            tc     <= 1'b0;
            halted <= 1'b0;
        end else if (load) begin
            tc     <= 1'b0;
            halted <= 1'b0;
        end else begin
            tc <= term_evt;
            if (term_evt && !wrap) begin
                halted <= 1'b1;
            end
        end
    end

endmodule
